rab_ar_port_buffer: RTL

- Per-port read-address front end for the RAB, one instance per port.
- Captures one slave-side AXI AR request and presents it to the RAB core lookup interface (addr/id/len/size/addr_valid/type/sent; accept/drop/out_addr).
- On accept, issues the translated request on the master AR channel.
- On drop, generates the AXI SLVERR read response locally, so the upstream master always completes its burst.

---
 rtl/rab_pkg.sv | 23 ++
 rtl/rab_ar_port_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rab_pkg.sv
// Shared types for the RAB per-port read-address front end.
package rab_pkg;

  // ID width carried in the captured request; ports must match this width.
  localparam int unsigned RAB_ID_WIDTH = 8;

  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SEND   = 2'd2,
    ST_ERR    = 2'd3
  } ar_state_e;

  typedef struct packed {
    logic [RAB_ID_WIDTH-1:0] id;
    logic [31:0]             addr;
    logic [7:0]              len;
    logic [2:0]              size;
  } ar_req_t;

endpackage

// File: rtl/rab_ar_port_buffer.sv
// Per-port AR front end: captures one slave AR, asks the RAB core for a
// translation, then either forwards it on the master AR channel or answers
// the whole burst locally with SLVERR beats.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new slave AR (arready high)
// LOOKUP | request presented to the core, waiting for accept/drop
// SEND   | translated request on master AR, waiting for arready
// ERR    | emitting len+1 SLVERR read beats to the upstream master
module rab_ar_port_buffer
  import rab_pkg::*;
#(
  parameter int unsigned C_AXI_ID_WIDTH   = RAB_ID_WIDTH,
  parameter int unsigned C_AXI_DATA_WIDTH = 64
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [C_AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [31:0]                 s_axi_araddr,
  input  logic [7:0]                  s_axi_arlen,
  input  logic [2:0]                  s_axi_arsize,
  input  logic                        s_axi_arvalid,
  output logic                        s_axi_arready,
  output logic [31:0]                 core_addr,
  output logic [C_AXI_ID_WIDTH-1:0]   core_id,
  output logic [7:0]                  core_len,
  output logic [2:0]                  core_size,
  output logic                        core_addr_valid,
  output logic                        core_type,
  output logic                        core_sent,
  input  logic [31:0]                 core_out_addr,
  input  logic                        core_accept,
  input  logic                        core_drop,
  output logic [C_AXI_ID_WIDTH-1:0]   m_axi_arid,
  output logic [31:0]                 m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic [2:0]                  m_axi_arsize,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  output logic [C_AXI_ID_WIDTH-1:0]   err_rid,
  output logic [C_AXI_DATA_WIDTH-1:0] err_rdata,
  output logic [1:0]                  err_rresp,
  output logic                        err_rlast,
  output logic                        err_rvalid,
  input  logic                        err_rready
);

  ar_state_e   state_q, state_d;
  ar_req_t     req_q, req_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        arready_q, arready_d;

  // Next-state, request capture, translated address and error beat counter.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    araddr_d  = araddr_q;
    cnt_d     = cnt_q;
    core_sent = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          req_d.id   = s_axi_arid;
          req_d.addr = s_axi_araddr;
          req_d.len  = s_axi_arlen;
          req_d.size = s_axi_arsize;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        // Accept has priority if the core ever raises both.
        if (core_accept) begin
          araddr_d = core_out_addr;
          state_d  = ST_SEND;
        end else if (core_drop) begin
          cnt_d   = req_q.len;
          state_d = ST_ERR;
        end
      end
      ST_SEND: begin
        if (m_axi_arready) begin
          core_sent = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (err_rready) begin
          if (cnt_q == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Registered ready: high exactly while the FSM sits in IDLE.
    arready_d = (state_d == ST_IDLE);
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      araddr_q  <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      araddr_q  <= araddr_d;
      cnt_q     <= cnt_d;
      arready_q <= arready_d;
    end
  end

  // Flags a core that claims both hit and miss for the same lookup.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_aresetn && state_q == ST_LOOKUP) begin
      assert (!(core_accept && core_drop))
        else $warning("rab_ar_port_buffer: core_accept and core_drop together, accept taken");
    end
  end

  assign s_axi_arready   = arready_q;

  assign core_addr       = req_q.addr;
  assign core_id         = req_q.id;
  assign core_len        = req_q.len;
  assign core_size       = req_q.size;
  assign core_addr_valid = (state_q == ST_LOOKUP);
  assign core_type       = 1'b0;

  assign m_axi_arid      = req_q.id;
  assign m_axi_araddr    = araddr_q;
  assign m_axi_arlen     = req_q.len;
  assign m_axi_arsize    = req_q.size;
  assign m_axi_arvalid   = (state_q == ST_SEND);

  assign err_rid         = req_q.id;
  assign err_rdata       = '0;
  assign err_rresp       = RESP_SLVERR;
  assign err_rvalid      = (state_q == ST_ERR);
  assign err_rlast       = (state_q == ST_ERR) && (cnt_q == 8'd0);

endmodule
